// File: rtl/switch_pkg.sv
// Shared types for the switch egress stage: port count, byte/port ids, read FSM states.
// No logic; pure declarations.
// Queue RAM word carries the packet-end flag beside each byte.
package switch_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [7:0] byte_t;
  typedef logic [1:0] port_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } egress_state_e;

  typedef struct packed {
    logic  last;
    byte_t data;
  } ram_word_t;

endpackage

// File: rtl/switch_egress_if.sv
// Bundle of the core write bus and the four reader-side egress handshakes.
// Wires only; no latency.
// Reader backpressure is expressed by holding read_N low.
interface switch_egress_if;
  import switch_pkg::*;

  // core -> egress write bus
  logic     wr_valid;
  port_id_t wr_port;
  byte_t    wr_data;
  logic     wr_last;

  // reader-side handshakes
  logic read_0, read_1, read_2, read_3;
  byte_t port0, port1, port2, port3;
  logic ready_0, ready_1, ready_2, ready_3;
  logic [NUM_PORTS-1:0] drop;

  modport master (
    output wr_valid, wr_port, wr_data, wr_last,
    output read_0, read_1, read_2, read_3,
    input  port0, port1, port2, port3,
    input  ready_0, ready_1, ready_2, ready_3,
    input  drop
  );

  modport slave (
    input  wr_valid, wr_port, wr_data, wr_last,
    input  read_0, read_1, read_2, read_3,
    output port0, port1, port2, port3,
    output ready_0, ready_1, ready_2, ready_3,
    output drop
  );

endinterface

// File: rtl/egress_port_queue.sv
// One egress port: packet-atomic byte queue with overflow rollback and a read FSM.
// Latency: write commit -> ready 2 edges; read sampled -> byte on port_data after the same edge.
// Backpressure: reader pauses with read low; a packet that overflows is dropped whole.
module egress_port_queue
  import switch_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  wr_en,
  input  byte_t wr_data,
  input  logic  wr_last,
  input  logic  read,
  output byte_t port_data,
  output logic  ready,
  output logic  drop
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] ptr_t;

  ram_word_t mem [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  ptr_t          wr_ptr;
  ptr_t          commit_ptr;
  ptr_t          rd_ptr;
  ptr_t          pkt_cnt;
  ptr_t          pkt_cnt_nxt;
  logic          ovf;
  egress_state_e state;

  logic      full;
  logic      wr_accept;
  logic      commit;
  logic      pkt_abort;
  logic      pop;
  logic      pop_last;
  logic      ready_d;
  ram_word_t rd_word;

  assign full      = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
  // Once a packet has overflowed, its remaining bytes are discarded too.
  assign wr_accept = wr_en && !full && !ovf;
  assign commit    = wr_accept && wr_last;
  assign pkt_abort = wr_en && wr_last && (full || ovf);

  assign rd_word   = mem[rd_ptr[PTR_W-1:0]];
  // In IDLE a pop needs the reader-visible ready; in XFER the packet is known complete.
  assign pop       = (state == IDLE) ? (ready && read) : read;
  assign pop_last  = pop && rd_word.last;

  // Packet count and the ready value it implies; a fresh commit is exposed one edge late.
  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (commit && !pop_last) begin
      pkt_cnt_nxt = pkt_cnt + ptr_t'(1);
    end else if (!commit && pop_last) begin
      pkt_cnt_nxt = pkt_cnt - ptr_t'(1);
    end
    ready_d = commit ? (pkt_cnt != '0) : (pkt_cnt_nxt != '0);
  end

  // Byte storage; the RAM itself is not reset, pointers make stale contents unreachable.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{last: wr_last, data: wr_data};
    end
  end

  // Write pointers, overflow rollback, packet count and the read FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      ovf        <= 1'b0;
      drop       <= 1'b0;
      ready      <= 1'b0;
      port_data  <= '0;
      state      <= IDLE;
    end else begin
      drop <= pkt_abort;

      if (pkt_abort) begin
        wr_ptr <= commit_ptr;
        ovf    <= 1'b0;
      end else if (wr_accept) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
        if (wr_last) begin
          commit_ptr <= wr_ptr + ptr_t'(1);
        end
      end else if (wr_en) begin
        ovf <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end

      pkt_cnt <= pkt_cnt_nxt;
      ready   <= ready_d;

      case (state)
        IDLE: begin
          if (pop) begin
            port_data <= rd_word.data;
            state     <= pop_last ? IDLE : XFER;
          end else begin
            port_data <= '0;
          end
        end
        XFER: begin
          if (pop) begin
            port_data <= rd_word.data;
            if (pop_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/switch_egress.sv
// Egress stage of the 4-port switch: demuxes core writes into four independent port queues.
// Latency: wr_last -> ready_N 2 edges; read_N -> portN byte 1 edge.
// Backpressure: per-port read_N pauses; full queues drop whole packets and pulse drop[N].
module switch_egress
  import switch_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input logic             clock,
  input logic             reset,
  switch_egress_if.slave  bus
);

  logic [NUM_PORTS-1:0] wr_sel;
  logic [NUM_PORTS-1:0] read_vec;
  logic [NUM_PORTS-1:0] ready_vec;
  logic [NUM_PORTS-1:0] drop_vec;
  byte_t                port_vec [NUM_PORTS];

  assign read_vec = {bus.read_3, bus.read_2, bus.read_1, bus.read_0};

  // Steer each written byte to exactly one destination queue.
  always_comb begin
    wr_sel = '0;
    if (bus.wr_valid) begin
      wr_sel[bus.wr_port] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    egress_port_queue #(
      .DEPTH(DEPTH)
    ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_sel[i]),
      .wr_data   (bus.wr_data),
      .wr_last   (bus.wr_last),
      .read      (read_vec[i]),
      .port_data (port_vec[i]),
      .ready     (ready_vec[i]),
      .drop      (drop_vec[i])
    );
  end

  assign bus.port0   = port_vec[0];
  assign bus.port1   = port_vec[1];
  assign bus.port2   = port_vec[2];
  assign bus.port3   = port_vec[3];
  assign bus.ready_0 = ready_vec[0];
  assign bus.ready_1 = ready_vec[1];
  assign bus.ready_2 = ready_vec[2];
  assign bus.ready_3 = ready_vec[3];
  assign bus.drop    = drop_vec;

endmodule

// File: tb/tb_switch_egress.sv
// Directed bench for switch_egress: packet delivery, back-to-back, pause, overflow drop,
// commit during last-byte read, and mid-transfer reset.
// Outputs are sampled 1 ns after each rising edge.
module tb_switch_egress;
  import switch_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  switch_egress_if bus ();

  switch_egress #(.DEPTH(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] port_of(input int n);
    case (n)
      0:       port_of = bus.port0;
      1:       port_of = bus.port1;
      2:       port_of = bus.port2;
      default: port_of = bus.port3;
    endcase
  endfunction

  function automatic logic ready_of(input int n);
    case (n)
      0:       ready_of = bus.ready_0;
      1:       ready_of = bus.ready_1;
      2:       ready_of = bus.ready_2;
      default: ready_of = bus.ready_3;
    endcase
  endfunction

  task automatic set_read(input int n, input logic v);
    case (n)
      0:       bus.read_0 = v;
      1:       bus.read_1 = v;
      2:       bus.read_2 = v;
      default: bus.read_3 = v;
    endcase
  endtask

  task automatic wr_byte(input int p, input byte_t d, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_port  = port_id_t'(p);
    bus.wr_data  = d;
    bus.wr_last  = last;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  // Advance one edge, then compare the port byte and ready flag it produced.
  task automatic tick_check(input int p, input byte_t exp_d, input logic exp_rdy, input string tag);
    tick();
    check($sformatf("%s port%0d data", tag, p), 32'(port_of(p)), 32'(exp_d));
    check($sformatf("%s ready_%0d", tag, p), 32'(ready_of(p)), 32'(exp_rdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_t p1 [5];
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_port  = '0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.read_0 = 1'b0;
    bus.read_1 = 1'b0;
    bus.read_2 = 1'b0;
    bus.read_3 = 1'b0;
    tick();
    tick();

    // Reset state
    for (int n = 0; n < 4; n++) begin
      check($sformatf("reset port%0d", n), 32'(port_of(n)), 32'h0);
      check($sformatf("reset ready_%0d", n), 32'(ready_of(n)), 32'h0);
    end
    check("reset drop", 32'(bus.drop), 32'h0);
    reset = 1'b0;
    tick();

    // 1: single 5-byte packet on port 1 with read_1 held throughout
    p1[0] = 8'h01; p1[1] = 8'h5A; p1[2] = 8'h03; p1[3] = 8'hD0; p1[4] = 8'hD1;
    bus.read_1 = 1'b1;
    for (int i = 0; i < 5; i++) wr_byte(1, p1[i], i == 4);
    check("t1 ready before latency", 32'(bus.ready_1), 32'h0);
    tick();
    check("t1 ready rise", 32'(bus.ready_1), 32'h1);
    check("t1 idle port1", 32'(bus.port1), 32'h0);
    for (int i = 0; i < 5; i++) tick_check(1, p1[i], i != 4, $sformatf("t1 byte%0d", i));
    tick();
    check("t1 port1 back to zero", 32'(bus.port1), 32'h0);
    bus.read_1 = 1'b0;

    // 2: two packets on port 2 read back-to-back
    for (int i = 0; i < 5; i++) wr_byte(2, byte_t'(8'h20 + i), i == 4);
    for (int i = 0; i < 5; i++) wr_byte(2, byte_t'(8'h40 + i), i == 4);
    tick();
    check("t2 ready", 32'(bus.ready_2), 32'h1);
    bus.read_2 = 1'b1;
    for (int i = 0; i < 5; i++) tick_check(2, byte_t'(8'h20 + i), 1'b1, $sformatf("t2 a%0d", i));
    for (int i = 0; i < 5; i++) tick_check(2, byte_t'(8'h40 + i), i != 4, $sformatf("t2 b%0d", i));
    bus.read_2 = 1'b0;

    // 3: pause read_3 for two cycles mid-packet
    for (int i = 0; i < 6; i++) wr_byte(3, byte_t'(8'h30 + i), i == 5);
    tick();
    bus.read_3 = 1'b1;
    tick_check(3, 8'h30, 1'b1, "t3 b0");
    tick_check(3, 8'h31, 1'b1, "t3 b1");
    bus.read_3 = 1'b0;
    tick_check(3, 8'h31, 1'b1, "t3 hold0");
    tick_check(3, 8'h31, 1'b1, "t3 hold1");
    bus.read_3 = 1'b1;
    for (int i = 2; i < 6; i++) tick_check(3, byte_t'(8'h30 + i), i != 5, $sformatf("t3 b%0d", i));
    bus.read_3 = 1'b0;

    // 4: overflow on port 0 drops the second packet whole
    for (int i = 0; i < 60; i++) wr_byte(0, byte_t'(i), i == 59);
    check("t4 no drop first", 32'(bus.drop), 32'h0);
    for (int i = 0; i < 10; i++) wr_byte(0, byte_t'(8'h80 + i), i == 9);
    check("t4 drop pulse", 32'(bus.drop), 32'h1);
    tick();
    check("t4 drop cleared", 32'(bus.drop), 32'h0);
    check("t4 ready_0", 32'(bus.ready_0), 32'h1);
    bus.read_0 = 1'b1;
    for (int i = 0; i < 60; i++) tick_check(0, byte_t'(i), i != 59, $sformatf("t4 b%0d", i));
    tick();
    check("t4 nothing more", 32'(bus.port0), 32'h0);
    check("t4 ready low", 32'(bus.ready_0), 32'h0);
    bus.read_0 = 1'b0;

    // 5: commit on port 0 lands on the same edge as the last-byte pop
    for (int i = 0; i < 3; i++) wr_byte(0, byte_t'(8'hA0 + i), i == 2);
    tick();
    check("t5 ready", 32'(bus.ready_0), 32'h1);
    bus.wr_valid = 1'b1; bus.wr_port = 2'd0; bus.wr_data = 8'hB0; bus.wr_last = 1'b0;
    tick();
    bus.read_0 = 1'b1;
    bus.wr_data = 8'hB1;
    tick_check(0, 8'hA0, 1'b1, "t5 a0");
    bus.wr_data = 8'hB2;
    tick_check(0, 8'hA1, 1'b1, "t5 a1");
    bus.wr_data = 8'hB3; bus.wr_last = 1'b1;
    tick_check(0, 8'hA2, 1'b1, "t5 a2 with commit");
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
    for (int i = 0; i < 4; i++) tick_check(0, byte_t'(8'hB0 + i), i != 3, $sformatf("t5 b%0d", i));
    bus.read_0 = 1'b0;

    // 6: reset in the middle of transfers on every port
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) wr_byte(n, byte_t'(8'h10 * (n + 1) + i), i == 3);
    tick();
    for (int n = 0; n < 4; n++) set_read(n, 1'b1);
    tick();
    check("t6 port0 mid", 32'(bus.port0), 32'h10);
    check("t6 port3 mid", 32'(bus.port3), 32'h40);
    bus.wr_valid = 1'b1; bus.wr_port = 2'd1; bus.wr_data = 8'h77; bus.wr_last = 1'b0;
    reset = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("t6 reset port%0d", n), 32'(port_of(n)), 32'h0);
      check($sformatf("t6 reset ready_%0d", n), 32'(ready_of(n)), 32'h0);
      set_read(n, 1'b0);
    end
    check("t6 reset drop", 32'(bus.drop), 32'h0);
    tick();
    tick();
    for (int n = 0; n < 4; n++)
      check($sformatf("t6 flushed ready_%0d", n), 32'(ready_of(n)), 32'h0);
    check("t6 no drop after flush", 32'(bus.drop), 32'h0);
    wr_byte(2, 8'hC1, 1'b0);
    wr_byte(2, 8'hC2, 1'b0);
    wr_byte(2, 8'hC3, 1'b1);
    tick();
    check("t6 fresh ready", 32'(bus.ready_2), 32'h1);
    bus.read_2 = 1'b1;
    tick_check(2, 8'hC1, 1'b1, "t6 c0");
    tick_check(2, 8'hC2, 1'b1, "t6 c1");
    tick_check(2, 8'hC3, 1'b0, "t6 c2");
    bus.read_2 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
